cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between the MIPS core's load/store port and the word-addressed data memory (4-word block read, single-word write). Holds tag/valid/data storage, runs the lookup/refill/write-through state machine, stalls the core, and keeps hit/miss statistics. It is the only master on the data-memory port.

## Interface
- `INDEX_W`, 2: index bits; the cache has 2^INDEX_W lines of 128 bits.
- `TAG_W`, 2: tag bits, taken from `cpu_addr[TAG_W+INDEX_W+1 : INDEX_W+2]`.
- `MEM_LAT`, 2: cycles `mem_rd_en` is held before `mem_rdata` is captured; must be ≥1.
- `clk`  in  1  system clock, rising-edge logic.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  access request, held by the core until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  word address; bits [1:0] = word offset in the block.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid while `cpu_ready` = 1.
- `cpu_ready`  out  1  one-cycle completion pulse; the core stalls while `cpu_req` = 1 and `cpu_ready` = 0.
- `mem_addr`  out  32  memory address: block-aligned for reads, word address for writes.
- `mem_wdata`  out  32  write-through data.
- `mem_wr_en`  out  1  memory write enable.
- `mem_rd_en`  out  1  memory block-read enable.
- `mem_rdata`  in  128  block {w3,w2,w1,w0}; undefined or high-Z whenever `mem_rd_en` = 0.
- `hit_cnt`  out  16  saturating hit counter.
- `miss_cnt`  out  16  saturating miss counter.

## Operation
- **States:** IDLE, LOOKUP, MEM_RD, REFILL, MEM_WR, RESP.
- **IDLE:** if `cpu_req` = 1, latch addr, we and wdata, then go to LOOKUP. Otherwise stay in IDLE.
- **LOOKUP:** hit = valid[idx] && tag[idx] == tag field.
  - Load hit → RESP, which returns the cached word.
  - Load miss → MEM_RD, with the counter cleared.
  - Store (hit or miss) → MEM_WR.
  - `hit_cnt` or `miss_cnt` increments once per request in this state. Both saturate at 0xFFFF.
- **MEM_RD:**
  - `mem_rd_en` = 1 and `mem_addr` = {latched addr[31:2], 2'b00} for exactly MEM_LAT cycles.
  - `mem_rdata` is captured on the last of those cycles, then the state goes to REFILL.
- **REFILL:**
  - Write the captured block into line idx, set its tag, and set valid = 1.
  - Load the requested word (selected by addr[1:0]) into the `cpu_rdata` register.
  - Go to RESP.
- **MEM_WR:**
  - One cycle with `mem_wr_en` = 1, `mem_addr` = latched word address and `mem_wdata` = latched data.
  - On a hit, update only the addressed 32-bit word of the line; tag and valid are unchanged.
  - On a miss, the cache array is unchanged (no allocate).
  - Go to RESP.
- **RESP:** `cpu_ready` = 1 for one cycle, then go to IDLE. For stores, `cpu_rdata` is 0.
- **Exclusivity:** `mem_rd_en` and `mem_wr_en` are never both 1. Both are 0 in IDLE, LOOKUP, REFILL and RESP.
- **Request changes:** changes to `cpu_req`, `cpu_addr`, `cpu_we` or `cpu_wdata` outside IDLE are ignored; the request is latched.
- **Back-to-back requests:** the core drops or changes `cpu_req` in the cycle after `cpu_ready`. A request still asserted in IDLE is treated as a new access.

## Timing
- Request seen in IDLE at cycle N. Every latency below is the cycle in which `cpu_ready` = 1:
  - Load hit: N+2.
  - Store (hit or miss): N+3; `mem_wr_en` at N+2.
  - Load miss: N+3+MEM_LAT; `mem_rd_en` from N+2 to N+1+MEM_LAT; REFILL at N+2+MEM_LAT.
- The memory writes on the falling edge of `clk`. `mem_wr_en`, `mem_addr` and `mem_wdata` are registered and stable for the whole MEM_WR cycle.
- **Reset** (synchronous, overrides any state, including mid-refill or mid-write):
  - State returns to IDLE and all valid bits are cleared.
  - `cpu_ready`, `mem_rd_en` and `mem_wr_en` are 0; `cpu_rdata`, `mem_addr` and `mem_wdata` are 0; `hit_cnt` and `miss_cnt` are 0.
  - A partially received block is discarded.
  - A write interrupted in MEM_WR may already have reached memory. The core must reissue it.
- Tag and data storage are not reset; only valid bits are.

## Structure
- **Package `cache_pkg`:**
  - state enum.
  - OFFSET_W = 2, BLOCK_W = 128, WORD_W = 32.
  - Address-field extraction functions (tag, index, offset).
  - Line type {valid, tag, data}.
- **Sub-module `cache_line_array`:**
  - 2^INDEX_W lines with asynchronous read.
  - Synchronous full-line write (refill).
  - Synchronous single-word write (store hit).
  - Synchronous valid clear on `reset`.
- The FSM, latches, MEM_LAT counter and stat counters stay in `cache_ctrl`.

## Test plan
- **Cold load miss:** reset; memory words 8..11 hold 0xA0..0xA3; load addr 9 → `mem_rd_en` for 2 cycles with `mem_addr` = 8, `cpu_ready` at N+5 with `cpu_rdata` = 0xA1, `miss_cnt` = 1.
- **Load hit:** after the miss above, load addr 11 → `cpu_ready` at N+2, `cpu_rdata` = 0xA3, no `mem_rd_en`, `hit_cnt` = 1.
- **Store hit then load:** store 0xDEADBEEF to addr 10 → `mem_wr_en` one cycle with `mem_addr` = 10; a following load of addr 10 hits and returns 0xDEADBEEF.
- **Store miss (no allocate):** store 0x1234 to addr 0x24 → memory written, `miss_cnt` +1; the next load of 0x24 misses and refills from block 0x24, returning 0x1234.
- **Conflict eviction:** load addr 8 (index 2, tag 0), then load addr 40 (same index, tag 2), then load addr 8 again → miss, miss, miss; `hit_cnt` unchanged.
- **Reset mid-refill:** assert `reset` during MEM_RD → next cycle IDLE, outputs 0, `cpu_ready` never pulses; reissuing the load gives a full miss sequence.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the direct-mapped cache controller.
//   state_t      controller states
//   line_t       one cache line {valid, tag, data}
//   addr_tag / addr_index / addr_offset   word-address field extraction
//   block_word   select one 32-bit word from a 128-bit block
package cache_pkg;

  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 128;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    REFILL,
    MEM_WR,
    RESP
  } state_t;

  // Tag is kept at full word width so the type does not depend on TAG_W;
  // bits above TAG_W are always written as zero.
  typedef struct packed {
    logic               valid;
    logic [WORD_W-1:0]  tag;
    logic [BLOCK_W-1:0] data;
  } line_t;

  function automatic logic [WORD_W-1:0] addr_tag(input logic [31:0] addr,
                                                 input int index_w,
                                                 input int tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return (addr >> (index_w + OFFSET_W)) & mask;
  endfunction

  function automatic logic [WORD_W-1:0] addr_index(input logic [31:0] addr,
                                                   input int index_w);
    logic [31:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return (addr >> OFFSET_W) & mask;
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: tag/valid/data storage for 2^INDEX_W lines.
//   idx        line selected for read and for both write kinds
//   line       asynchronous read of the selected line
//   fill_*     full-line write (refill), also sets valid
//   word_*     single-word write into an existing line (store hit)
//   reset      synchronous clear of the valid bits only
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  idx,
  output line_t               line,
  input  logic                fill_en,
  input  logic [WORD_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                word_en,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid;
  logic [WORD_W-1:0]  tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_data;
    end else if (word_en) begin
      data_mem[idx][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

  always_comb begin
    line.valid = valid[idx];
    line.tag   = tag_mem[idx];
    line.data  = data_mem[idx];
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache between
// the core load/store port and word-addressed data memory.
//   cpu_*     core side: request held until the one-cycle cpu_ready pulse
//   mem_*     memory side: 4-word block read (mem_rd_en), single-word write
//   hit_cnt / miss_cnt   saturating statistics, one count per request
//
// state  | meaning
// IDLE   | waiting; latches the request when cpu_req = 1
// LOOKUP | tag compare, statistics update, choose path
// MEM_RD | block read held MEM_LAT cycles, block captured on the last one
// REFILL | write block into the line, pick requested word
// MEM_WR | one-cycle write-through, updates line only on a hit
// RESP   | cpu_ready pulse
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 2,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [127:0]  mem_rdata,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  state_t               state, next_state;
  logic [31:0]          addr_q, wdata_q;
  logic                 we_q, hit_q;
  logic [CNT_W-1:0]     cnt;
  logic [BLOCK_W-1:0]   blk_q;
  logic [INDEX_W-1:0]   idx;
  logic [WORD_W-1:0]    tag_f;
  logic [OFFSET_W-1:0]  off;
  line_t                line;
  logic                 hit, rd_last;

  // Next values of the registered outputs, decoded from next_state so each
  // output is already stable at the start of the state it belongs to.
  logic                 cpu_ready_d, mem_rd_en_d, mem_wr_en_d;
  logic [31:0]          cpu_rdata_d, mem_addr_d, mem_wdata_d;

  assign idx     = INDEX_W'(addr_index(addr_q, INDEX_W));
  assign tag_f   = addr_tag(addr_q, INDEX_W, TAG_W);
  assign off     = addr_offset(addr_q);
  assign hit     = line.valid && (line.tag == tag_f);
  assign rd_last = (cnt == CNT_W'(MEM_LAT - 1));

  cache_line_array #(.INDEX_W(INDEX_W)) u_array (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .line      (line),
    .fill_en   (state == REFILL),
    .fill_tag  (tag_f),
    .fill_data (blk_q),
    .word_en   ((state == MEM_WR) && hit_q),
    .word_off  (off),
    .word_data (wdata_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = LOOKUP;
      LOOKUP:  if (we_q)    next_state = MEM_WR;
               else if (hit) next_state = RESP;
               else          next_state = MEM_RD;
      MEM_RD:  if (rd_last) next_state = REFILL;
      REFILL:  next_state = RESP;
      MEM_WR:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    cpu_rdata_d = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (next_state)
      MEM_RD: begin
        mem_rd_en_d = 1'b1;
        mem_addr_d  = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      MEM_WR: begin
        mem_wr_en_d = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
      end
      RESP: begin
        cpu_ready_d = 1'b1;
        if (!we_q) begin
          cpu_rdata_d = (state == REFILL) ? block_word(blk_q, off)
                                          : block_word(line.data, off);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hit_q     <= 1'b0;
      cnt       <= '0;
      blk_q     <= '0;
      cpu_ready <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= cpu_ready_d;
      mem_rd_en <= mem_rd_en_d;
      mem_wr_en <= mem_wr_en_d;
      cpu_rdata <= cpu_rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (state == LOOKUP) begin
        hit_q <= hit;
        cnt   <= '0;
        if (hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (state == MEM_RD) begin
        cnt <= cnt + 1'b1;
        if (rd_last) blk_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_wr_en, mem_rd_en;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] junk;
  logic [7:0]  rb;

  bit m_valid [4];
  int m_tag   [4];
  int m_hits, m_misses;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          miss;
    logic [31:0] rdata;
    int          hits;
    int          misses;
  } vec_t;
  vec_t vt [9];

  cache_ctrl #(.INDEX_W(2), .TAG_W(2), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: block read is combinational while mem_rd_en, garbage otherwise;
  // writes land on the falling edge.
  always_comb begin
    rb = {mem_addr[7:2], 2'b00};
    if (mem_rd_en) mem_rdata = {mem[rb+8'd3], mem[rb+8'd2], mem[rb+8'd1], mem[rb]};
    else           mem_rdata = {4{junk}};
  end

  always @(negedge clk) begin
    junk = $urandom;
    if (mem_wr_en) mem[mem_addr[7:0]] = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, cpu_ready}, 32'd0);
    check({tag, "_rd_en"},  {31'd0, mem_rd_en}, 32'd0);
    check({tag, "_wr_en"},  {31'd0, mem_wr_en}, 32'd0);
    check({tag, "_rdata"},  cpu_rdata, 32'd0);
    check({tag, "_maddr"},  mem_addr, 32'd0);
    check({tag, "_mwdata"}, mem_wdata, 32'd0);
    check({tag, "_hits"},   {16'd0, hit_cnt}, 32'd0);
    check({tag, "_misses"}, {16'd0, miss_cnt}, 32'd0);
  endtask

  // Runs one request starting in an IDLE cycle. Reports latency in cycles
  // (0 = timed out), returned data and the number of cycles whose memory
  // strobes/address/data deviated from the expected pattern.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit miss, output int lat, output logic [31:0] rdata,
                        output int bad);
    bit exp_rd, exp_wr;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; rdata = '0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      exp_rd = !we && miss && c >= 2 && c <= 1 + MEM_LAT;
      exp_wr = we && c == 2;
      if (mem_rd_en !== exp_rd || mem_wr_en !== exp_wr) bad++;
      if (exp_rd && mem_addr !== {addr[31:2], 2'b00}) bad++;
      if (exp_wr && (mem_addr !== addr || mem_wdata !== wd)) bad++;
      if (c == 1) begin
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom_range(0, 1));
      end
      if (cpu_ready) begin
        lat = c; rdata = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    if (cpu_ready !== 1'b0) bad++;
  endtask

  task automatic run_and_check(input string name, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input bit miss, input logic [31:0] exp_rdata,
                               input int exp_hits, input int exp_misses);
    int lat, bad, exp_lat;
    logic [31:0] rd;
    exp_lat = we ? 3 : (miss ? 3 + MEM_LAT : 2);
    access(we, addr, wd, miss, lat, rd, bad);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_rdata"}, rd, exp_rdata);
    check({name, "_strobes"}, bad, 0);
    check({name, "_hit_cnt"}, {16'd0, hit_cnt}, exp_hits);
    check({name, "_miss_cnt"}, {16'd0, miss_cnt}, exp_misses);
    if (we) check({name, "_memword"}, mem[addr[7:0]], wd);
  endtask

  initial begin
    int seen_ready, seen_rd;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; junk = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h100 + i;
      ref_mem[i] = 32'h100 + i;
    end
    for (int i = 0; i < 4; i++) begin
      mem[8+i] = 32'hA0 + i;
      ref_mem[8+i] = 32'hA0 + i;
    end

    vt[0] = '{0, 32'd9,    32'h0,        1, 32'hA1,       0, 1};
    vt[1] = '{0, 32'd11,   32'h0,        0, 32'hA3,       1, 1};
    vt[2] = '{1, 32'd10,   32'hDEADBEEF, 0, 32'h0,        2, 1};
    vt[3] = '{0, 32'd10,   32'h0,        0, 32'hDEADBEEF, 3, 1};
    vt[4] = '{1, 32'h24,   32'h1234,     1, 32'h0,        3, 2};
    vt[5] = '{0, 32'h24,   32'h0,        1, 32'h1234,     3, 3};
    vt[6] = '{0, 32'd40,   32'h0,        1, 32'h128,      3, 4};
    vt[7] = '{0, 32'd8,    32'h0,        1, 32'hA0,       3, 5};
    vt[8] = '{0, 32'd40,   32'h0,        1, 32'h128,      3, 6};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].miss,
                    vt[i].rdata, vt[i].hits, vt[i].misses);
      if (vt[i].we) ref_mem[vt[i].addr[7:0]] = vt[i].wdata;
    end

    // Reset in the last MEM_RD cycle of a load miss to address 50.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd50; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("midrefill_rd_en", {31'd0, mem_rd_en}, 32'd1);
    cpu_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrefill");
    reset = 1'b0;
    seen_ready = 0; seen_rd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) seen_ready++;
      if (mem_rd_en || mem_wr_en) seen_rd++;
    end
    check("midrefill_no_ready", seen_ready, 0);
    check("midrefill_no_mem", seen_rd, 0);
    run_and_check("reissue50", 0, 32'd50, 32'h0, 1, ref_mem[50], 0, 1);
    run_and_check("after_reset_9", 0, 32'd9, 32'h0, 1, ref_mem[9], 0, 2);

    // Model state after the two loads above: line0 tag3, line2 tag0.
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
    m_valid[0] = 1; m_tag[0] = 3;
    m_valid[2] = 1; m_tag[2] = 0;
    m_hits = 0; m_misses = 2;

    for (int n = 0; n < 300; n++) begin
      bit we, hit;
      int addr, ix, tg;
      logic [31:0] wd, exp_rd;
      we   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 63);
      wd   = $urandom;
      ix   = (addr / 4) % 4;
      tg   = (addr / 16) % 4;
      hit  = m_valid[ix] && m_tag[ix] == tg;
      exp_rd = we ? 32'd0 : ref_mem[addr];
      if (hit) m_hits++; else m_misses++;
      if (!we && !hit) begin
        m_valid[ix] = 1;
        m_tag[ix] = tg;
      end
      run_and_check($sformatf("rnd%0d", n), we, 32'(addr), wd, !hit, exp_rd, m_hits, m_misses);
      if (we) ref_mem[addr] = wd;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
